// File: rtl/pattern_scan_ctrl.sv
// Programmable serial pattern-scan controller.
// Latches a target pattern and window length on start, then scans exactly
// win_len accepted stream bits, pulsing match for each (overlapping)
// occurrence, counting occurrences, and pulsing done on normal completion.
module pattern_scan_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] win_len,
    input  logic             a,
    input  logic             a_valid,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [PAT_W-1:0]   pat_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic [PAT_W-2:0]   hist;
    logic [FILL_W-1:0]  fill;

    logic [PAT_W-1:0]   shifted;
    logic               take;
    logic               hit;
    logic               last_bit;

    // Qualify the incoming bit and evaluate hit / window-end for this cycle.
    always_comb begin
        shifted  = {hist, a};
        take     = (state == RUN) && a_valid && !abort;
        hit      = take && (fill == FILL_MAX) && (shifted == pat_q);
        last_bit = take && ((bit_cnt + CNT_W'(1)) == len_q);
    end

    // Scan sequencer with registered busy/match/done outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            match     <= 1'b0;
            done      <= 1'b0;
            match_cnt <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            hist      <= '0;
            fill      <= '0;
            bit_cnt   <= '0;
        end else begin
            match <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_q     <= pat_in;
                        len_q     <= win_len;
                        hist      <= '0;
                        fill      <= '0;
                        bit_cnt   <= '0;
                        match_cnt <= '0;
                        if (win_len != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (a_valid) begin
                        hist    <= shifted[PAT_W-2:0];
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (fill != FILL_MAX)
                            fill <= fill + FILL_W'(1);
                        if (hit) begin
                            match     <= 1'b1;
                            match_cnt <= match_cnt + CNT_W'(1);
                        end
                        if (last_bit) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: the driver feeds scans and pushes
// the expected match/done events from a bit-queue reference model; a negedge
// monitor pops and compares whenever the DUT raises match or done.
module tb_pattern_scan_ctrl;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pat_in;
    logic [CNT_W-1:0] win_len;
    logic             a;
    logic             a_valid;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             done;

    bit clk_run = 1'b1;
    always #5 if (clk_run) clk = ~clk;

    pattern_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pat_in(pat_in), .win_len(win_len), .a(a), .a_valid(a_valid),
        .busy(busy), .match(match), .match_cnt(match_cnt), .done(done)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic             m;
        logic             d;
        logic [CNT_W-1:0] cnt;
    } ev_t;
    ev_t exp_q[$];

    // reference model: the accepted bits of the current scan, kept verbatim
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    int               m_acc;
    int               m_cnt;
    bit               m_bits[$];
    bit               fixed_bits[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // occurrence = last PAT_W accepted bits equal the pattern, MSB first
    task automatic m_accept(input bit b);
        bit hit;
        bit fin;
        int n;
        m_bits.push_back(b);
        m_acc++;
        n   = m_bits.size();
        hit = (n >= PAT_W);
        if (hit)
            for (int i = 0; i < PAT_W; i++)
                if (m_bits[n - PAT_W + i] != m_pat[PAT_W-1-i]) hit = 1'b0;
        if (hit) m_cnt++;
        fin = (m_acc == m_len);
        if (hit || fin) exp_q.push_back('{m: hit, d: fin, cnt: CNT_W'(m_cnt)});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // monitor: every match/done presentation must match the next expected event
    always @(negedge clk) begin
        if (reset === 1'b1 && (match === 1'b1 || done === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got match=%0b done=%0b cnt=%0d expected no event",
                         match, done, match_cnt);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("match", match, e.m);
                chk("done", done, e.d);
                chk("match_cnt", match_cnt, e.cnt);
            end
        end
    end

    task automatic scan(input logic [PAT_W-1:0] pat, input int len, input int abort_after,
                        input int vpct, input bit fixed, input bit hold);
        int idx;
        bit v;
        bit b;
        idx     = 0;
        start   = 1'b1;
        pat_in  = pat;
        win_len = CNT_W'(len);
        m_pat   = pat;
        m_len   = len;
        m_acc   = 0;
        m_cnt   = 0;
        m_bits.delete();
        tick;
        if (hold) begin
            pat_in  = ~pat;
            win_len = CNT_W'(2);
        end else begin
            start = 1'b0;
        end
        chk("cnt_cleared_on_start", match_cnt, 0);
        if (len == 0) begin
            exp_q.push_back('{m: 1'b0, d: 1'b1, cnt: '0});
            chk("busy_zero_len", busy, 0);
            tick;
            chk("busy_after_zero_len", busy, 0);
            chk("done_zero_len_single", done, 0);
            return;
        end
        chk("busy_after_start", busy, 1);
        while (m_acc < len) begin
            if (abort_after >= 0 && m_acc == abort_after) begin
                abort   = 1'b1;
                a_valid = 1'b1;
                a       = 1'($urandom);
                tick;
                abort   = 1'b0;
                a_valid = 1'b0;
                chk("busy_after_abort", busy, 0);
                chk("cnt_after_abort", match_cnt, m_cnt);
                chk("done_after_abort", done, 0);
                tick;
                chk("no_late_done", done, 0);
                return;
            end
            v = ($urandom_range(99) < vpct);
            b = (fixed && idx < fixed_bits.size()) ? fixed_bits[idx] : 1'($urandom);
            a       = b;
            a_valid = v;
            tick;
            if (v) begin
                m_accept(b);
                idx++;
            end
            if (m_acc < len) chk("busy_in_run", busy, 1);
        end
        a_valid = 1'b0;
        chk("busy_in_done", busy, 0);
        tick;
        chk("busy_back_idle", busy, 0);
        chk("done_single_cycle", done, 0);
        chk("cnt_holds", match_cnt, m_cnt);
    endtask

    // reset-mid-run scenario, including a reset pulse while the clock is stopped
    task automatic reset_mid_run;
        start   = 1'b1;
        pat_in  = '0;
        win_len = CNT_W'(20);
        m_pat   = '0;
        m_len   = 20;
        m_acc   = 0;
        m_cnt   = 0;
        m_bits.delete();
        tick;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a       = 1'b0;
            a_valid = 1'b1;
            tick;
            m_accept(1'b0);
        end
        a_valid = 1'b0;
        tick;
        @(negedge clk);
        clk_run = 1'b0;
        #2 reset = 1'b0;
        #10 reset = 1'b1;
        #2 clk_run = 1'b1;
        tick;
        chk("stall_reset_busy", busy, 1);
        chk("stall_reset_cnt", match_cnt, m_cnt);
        a       = 1'b0;
        a_valid = 1'b1;
        reset   = 1'b0;
        tick;
        reset   = 1'b1;
        a_valid = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_match", match, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", match_cnt, 0);
        tick;
        chk("rst_stays_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pat_in  = '0;
        win_len = '0;
        a       = 1'b0;
        a_valid = 1'b0;
        repeat (3) tick;
        chk("reset_busy", busy, 0);
        chk("reset_match", match, 0);
        chk("reset_done", done, 0);
        chk("reset_cnt", match_cnt, 0);
        reset = 1'b1;
        tick;

        fixed_bits = '{1, 1, 0, 1, 1, 0, 1};
        scan(4'b1101, 7, -1, 100, 1'b1, 1'b0);
        chk("overlap_count", match_cnt, 2);

        fixed_bits = '{1, 1, 0, 1, 0, 0};
        scan(4'b1101, 6, -1, 60, 1'b1, 1'b0);
        chk("gapped_count", match_cnt, 1);

        scan(4'b1101, 0, -1, 100, 1'b0, 1'b0);

        fixed_bits = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        scan(4'b1101, 10, 5, 100, 1'b1, 1'b0);
        chk("abort_partial_count", match_cnt, 1);

        reset_mid_run();

        scan(4'b1101, 3, -1, 100, 1'b0, 1'b1);
        scan(4'b0010, 2, -1, 100, 1'b0, 1'b0);

        repeat (40) begin
            int len;
            int ab;
            len = $urandom_range(25);
            ab  = ($urandom_range(3) == 0 && len > 0) ? $urandom_range(len - 1) : -1;
            scan(PAT_W'($urandom), len, ab, 75, 1'b0, 1'b0);
        end

        repeat (3) tick;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Programmable serial pattern-scan controller: captures a PAT_W-bit target pattern and a window length on start, then scans a qualified serial bit stream for exactly win_len accepted bits.
- Flags each overlapping occurrence with a registered Moore-style match pulse and counts occurrences.
- Reports completion with a one-cycle done pulse.
- Sequences the snail-style recognizer function under software/FSM control; replaces hard-coded per-pattern detectors.

Parameters:
- PAT_W, 4, pattern length in bits (>=2); pat_in[PAT_W-1] is the first bit expected on the stream.
- CNT_W, 8, width of window length and match counter.

Ports:
- clk  input  1  single clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk; 0 = reset.
- start  input  1  begin a scan; honoured only in IDLE.
- abort  input  1  cancel a scan; honoured only in RUN.
- pat_in  input  PAT_W  target pattern, latched on accepted start.
- win_len  input  CNT_W  number of stream bits to scan, latched on accepted start.
- a  input  1  serial stream bit.
- a_valid  input  1  a is accepted this cycle (RUN only).
- busy  output  1  high while in RUN.
- match  output  1  registered one-cycle pulse per detected occurrence.
- match_cnt  output  CNT_W  occurrences in current/last scan; holds until next accepted start.
- done  output  1  one-cycle pulse on normal scan completion.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; busy=0, match=0, done=0, match_cnt=0; pattern, length, history, fill and bit counters cleared. Reset overrides every other input, including mid-scan.
- States: IDLE, RUN, DONE; encoded in a 2-bit register; unused code goes to IDLE.
- IDLE:
  - start=1 latches pat_q<=pat_in and len_q<=win_len; clears history, fill, bit_cnt and match_cnt.
  - Next state is RUN if win_len!=0, else DONE.
  - start=0: stay in IDLE.
- RUN:
  - busy=1. start is ignored.
  - Each cycle with a_valid=1: hist<={hist[PAT_W-2:0],a}; fill increments, saturating at PAT_W-1; bit_cnt increments.
  - Hit: fill==PAT_W-1 and {hist[PAT_W-2:0],a}==pat_q. On a hit, match=1 in the next cycle and match_cnt increments.
  - Overlap allowed: history is not cleared after a hit (1101 in 1101101 hits twice).
  - Cycles with a_valid=0 change nothing.
  - Accepted bit with bit_cnt+1==len_q: next state DONE. A hit on that bit still pulses match and is counted, in the same cycle done rises.
  - abort=1 in RUN: next state IDLE with no done pulse and no further bits accepted. abort wins over a_valid in the same cycle, so that bit is discarded. match_cnt holds its partial value.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE unconditionally. start is ignored in DONE.
- Latency:
  - start to busy: 1 cycle.
  - completing bit to match: 1 cycle.
  - last bit to done: 1 cycle.
  - win_len==0: done 1 cycle after start, match_cnt=0.
- match_cnt cannot overflow, since hits <= win_len <= 2^CNT_W-1. No saturation logic is needed.
- Outputs are registered or decoded directly from state; no combinational path from a to outputs.

Test Plan:
- PAT_W=4, pat_in=4'b1101, win_len=7, stream 1,1,0,1,1,0,1 (a_valid every cycle) -> match pulses after bits 4 and 7; match_cnt=2; done pulses together with the second match; busy high for 7 cycles.
- Same pattern, win_len=6, stream 1,1,0,1 with a_valid=0 on 3 interleaved cycles, then 0,0 -> single match after the 4th accepted bit; done after the 6th accepted bit; match_cnt=1.
- win_len=0 with start -> RUN skipped; done one cycle after start; busy stays 0; match_cnt=0.
- win_len=10, abort asserted after 5 accepted bits that contain one hit -> IDLE next cycle; no done pulse; match_cnt=1; next start clears match_cnt to 0.
- reset driven low for 1 cycle mid-RUN -> next cycle busy=0, match=0, done=0, match_cnt=0. Reset asserted while clk is stalled has no effect until the next posedge.
- start held high through RUN and DONE -> ignored; a second scan begins only from IDLE; new pat_in/win_len latched only then.
